// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch handshake and byte-load port between CPU/loader (master) and instruction memory (slave)
interface imem_fetch_if #(parameter int ADDR_W = 10, parameter int INSTR_W = 32);
  logic               READ;
  logic [ADDR_W-1:0]  ADDRESS;
  logic               BUSYWAIT;
  logic [INSTR_W-1:0] INSTRUCTION;
  logic               MISALIGN;
  logic               LOAD_WE;
  logic [ADDR_W-1:0]  LOAD_ADDR;
  logic [7:0]         LOAD_DATA;
  modport master (output READ, ADDRESS, LOAD_WE, LOAD_ADDR, LOAD_DATA,
                  input BUSYWAIT, INSTRUCTION, MISALIGN);
  modport slave (input READ, ADDRESS, LOAD_WE, LOAD_ADDR, LOAD_DATA,
                 output BUSYWAIT, INSTRUCTION, MISALIGN);
endinterface

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-addressed multi-cycle instruction memory; optional last-address hit buffer via IMEM_LAST_HIT_EN
module imem_fetch_unit #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32,
  parameter int LATENCY = 4
) (
  input logic         CLK,
  input logic         RESET,
  imem_fetch_if.slave bus
);
  localparam int NB = INSTR_W / 8;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         mem [2**ADDR_W];
  logic [INSTR_W-1:0] word;
  logic               hit;
  logic               capture;
  assign capture = state == WAIT && cnt == '0;
  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign word[8*i +: 8] = mem[addr_q + ADDR_W'(i)];
  end
`ifdef IMEM_LAST_HIT_EN
  logic [ADDR_W-1:0] tag_q;
  logic              tag_v;
  assign hit = tag_v && bus.ADDRESS == tag_q;
  // Any load may touch the buffered word, so it simply drops the tag.
  always_ff @(posedge CLK) begin
    if (!RESET || bus.LOAD_WE) tag_v <= 1'b0;
    else if (capture) begin
      tag_v <= 1'b1;
      tag_q <= addr_q;
    end
  end
`else
  assign hit = 1'b0;
`endif
  assign bus.BUSYWAIT = state == IDLE ? bus.READ && !hit : state == WAIT;
  always_ff @(posedge CLK) if (bus.LOAD_WE) mem[bus.LOAD_ADDR] <= bus.LOAD_DATA;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      bus.INSTRUCTION <= '0;
      bus.MISALIGN    <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.READ && !hit) begin
        addr_q <= bus.ADDRESS;
        cnt    <= CW'(LATENCY - 1);
        state  <= WAIT;
      end
    end else if (state == WAIT) begin
      if (capture) begin
        bus.INSTRUCTION <= word;
        bus.MISALIGN    <= (addr_q % ADDR_W'(NB)) != '0;
        state           <= RESP;
      end else cnt <= cnt - 1'b1;
    end else state <= IDLE;
  end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed self-checking bench for imem_fetch_unit (ADDR_W=10, INSTR_W=32, LATENCY=4)
module tb_imem_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  imem_fetch_if #(.ADDR_W(10), .INSTR_W(32)) bus ();
  imem_fetch_unit #(.ADDR_W(10), .INSTR_W(32), .LATENCY(4)) dut (.CLK(clk), .RESET(rst_n), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    bus.LOAD_WE = 1'b1;
    bus.LOAD_ADDR = a;
    bus.LOAD_DATA = d;
    step();
    bus.LOAD_WE = 1'b0;
  endtask

  // Counts stall cycles from the request cycle up to the RESP (or hit) cycle, then returns to IDLE.
  task automatic fetch(input logic [9:0] a, input int exp_busy, input logic [31:0] exp_i,
                       input logic exp_m, input string tag);
    int n = 0;
    bus.READ = 1'b1;
    bus.ADDRESS = a;
    #1;
    while (bus.BUSYWAIT && n < 20) begin
      n++;
      step();
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
    chk({tag, " instr"}, 64'(bus.INSTRUCTION), 64'(exp_i));
    chk({tag, " misalign"}, 64'(bus.MISALIGN), 64'(exp_m));
    bus.READ = 1'b0;
    step();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.READ = 1'b0;
    bus.ADDRESS = '0;
    bus.LOAD_WE = 1'b0;
    bus.LOAD_ADDR = '0;
    bus.LOAD_DATA = '0;
    step();
    step();
    chk("reset instr", 64'(bus.INSTRUCTION), 64'h0);
    chk("reset misalign", 64'(bus.MISALIGN), 64'h0);
    chk("reset busy idle", 64'(bus.BUSYWAIT), 64'h0);
    bus.READ = 1'b1;
    #1;
    chk("reset busy=read", 64'(bus.BUSYWAIT), 64'h1);
    bus.READ = 1'b0;
    load(10'd0, 8'h78);
    load(10'd1, 8'h00);
    load(10'd2, 8'h04);
    load(10'd3, 8'h07);
    load(10'd4, 8'h02);
    load(10'd5, 8'h04);
    load(10'd6, 8'h05);
    load(10'd7, 8'h0C);
    load(10'd1022, 8'hAA);
    load(10'd1023, 8'hBB);
    rst_n = 1'b1;
    fetch(10'd0, 5, 32'h07040078, 1'b0, "basic");
    repeat (3) step();
    chk("hold instr", 64'(bus.INSTRUCTION), 64'h07040078);
    // back-to-back 0 then 4 (reload clears any buffered tag)
    load(10'd0, 8'h78);
    bus.READ = 1'b1;
    bus.ADDRESS = 10'd0;
    #1;
    n = 0;
    while (bus.BUSYWAIT && n < 20) begin n++; step(); end
    chk("b2b first busy", 64'(n), 64'd5);
    chk("b2b first instr", 64'(bus.INSTRUCTION), 64'h07040078);
    bus.ADDRESS = 10'd4;
    step();
    chk("b2b second rise", 64'(bus.BUSYWAIT), 64'h1);
    n = 0;
    while (bus.BUSYWAIT && n < 20) begin n++; step(); end
    chk("b2b second busy", 64'(n), 64'd5);
    chk("b2b second instr", 64'(bus.INSTRUCTION), 64'h0C050402);
    bus.READ = 1'b0;
    step();
    fetch(10'd1022, 5, 32'h0078BBAA, 1'b1, "wrap");
    // reset in WAIT aborts the fetch
    bus.READ = 1'b1;
    bus.ADDRESS = 10'd0;
    step();
    step();
    chk("abort in wait", 64'(bus.BUSYWAIT), 64'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort instr", 64'(bus.INSTRUCTION), 64'h0);
    chk("abort misalign", 64'(bus.MISALIGN), 64'h0);
    chk("abort busy=read1", 64'(bus.BUSYWAIT), 64'h1);
    bus.READ = 1'b0;
    #1;
    chk("abort busy=read0", 64'(bus.BUSYWAIT), 64'h0);
    repeat (8) step();
    chk("abort no resp", 64'(bus.INSTRUCTION), 64'h0);
    // load to in-flight word before capture is seen; READ dropped during WAIT
    bus.READ = 1'b1;
    bus.ADDRESS = 10'd0;
    step();
    bus.READ = 1'b0;
    bus.LOAD_WE = 1'b1;
    bus.LOAD_ADDR = 10'd2;
    bus.LOAD_DATA = 8'hFF;
    step();
    bus.LOAD_WE = 1'b0;
    n = 0;
    while (bus.BUSYWAIT && n < 20) begin n++; step(); end
    chk("early write busy", 64'(n), 64'd3);
    chk("early write instr", 64'(bus.INSTRUCTION), 64'h07FF0078);
    step();
    load(10'd2, 8'h04);
    // load on the capture edge is not seen
    bus.READ = 1'b1;
    bus.ADDRESS = 10'd0;
    step();
    bus.READ = 1'b0;
    step();
    step();
    step();
    bus.LOAD_WE = 1'b1;
    bus.LOAD_ADDR = 10'd2;
    bus.LOAD_DATA = 8'hFF;
    step();
    bus.LOAD_WE = 1'b0;
    chk("capture write resp", 64'(bus.BUSYWAIT), 64'h0);
    chk("capture write instr", 64'(bus.INSTRUCTION), 64'h07040078);
    step();
    fetch(10'd0, 5, 32'h07FF0078, 1'b0, "after capture write");
`ifdef IMEM_LAST_HIT_EN
    fetch(10'd0, 0, 32'h07FF0078, 1'b0, "repeat hit");
`else
    fetch(10'd0, 5, 32'h07FF0078, 1'b0, "repeat nohit");
`endif
    load(10'd3, 8'h07);
    fetch(10'd0, 5, 32'h07FF0078, 1'b0, "after load");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
